// File: rtl/booth_div_pkg.sv
// Shared types, constants and helpers for the sequential restoring divider.
package booth_div_pkg;

  localparam int DEF_WIDTH = 16;

  // Widest operand abs_val can handle; callers sign-extend into this width.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Magnitude of a sign-extended operand. Only negates in signed mode, so
  // the most negative value maps to its own unsigned bit pattern.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                               input logic            is_signed);
    if (is_signed && v[MAX_W-1]) begin
      return -v;
    end
    return v;
  endfunction

endpackage

// File: rtl/booth_lshift_reg.sv
// Left-shifting {R,Q} register: parallel load has priority over shift.
module booth_lshift_reg
  import booth_div_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         ld,
  input  logic         shift,
  input  logic [2*W:0] d_in,
  input  logic         lsb_in,
  output logic [2*W:0] q
);

  logic [2*W:0] reg_d;
  logic [2*W:0] reg_q;

  // Next-value selection: load, shift left with lsb_in, or hold.
  always_comb begin
    // NOTE: default first so every path assigns reg_d and no latch is inferred.
    reg_d = reg_q;
    if (ld) begin
      reg_d = d_in;
    end else if (shift) begin
      reg_d = {reg_q[2*W-1:0], lsb_in};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      // NOTE: non-blocking assignments in clocked blocks avoid read/write races.
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, with
// start/busy/done handshake and optional two's complement operands.
module booth_seq_divider
  import booth_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dz_flag_q, dz_flag_d;

  // Shift register interface.
  logic               sr_ld;
  logic               sr_shift;
  logic [2*WIDTH:0]   sr_din;
  logic               sr_lsb;
  logic [2*WIDTH:0]   rq;

  // Datapath views of the {R,Q} register.
  logic [WIDTH-1:0]   q_cur;
  logic [WIDTH-1:0]   r_mag;
  logic [2*WIDTH:0]   rq_shl;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH+1:0]   diff;
  logic               fits;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;

  booth_lshift_reg #(.W(WIDTH)) u_rq (
    .clk    (clk),
    .clr_n  (clr_n),
    .ld     (sr_ld),
    .shift  (sr_shift),
    .d_in   (sr_din),
    .lsb_in (sr_lsb),
    .q      (rq)
  );

  // Operand magnitudes, remainder trial subtraction and result views.
  always_comb begin
    dvd_mag = WIDTH'(abs_val({{(MAX_W-WIDTH){dividend[WIDTH-1]}}, dividend}, signed_en));
    dvs_mag = WIDTH'(abs_val({{(MAX_W-WIDTH){divisor[WIDTH-1]}}, divisor}, signed_en));
    q_cur   = rq[WIDTH-1:0];
    r_mag   = WIDTH'(rq[2*WIDTH:WIDTH]);
    rq_shl  = {rq[2*WIDTH-1:0], 1'b0};
    r_sh    = rq_shl[2*WIDTH:WIDTH];
    diff    = {1'b0, r_sh} - {2'b00, dvs_q};
    fits    = ~diff[WIDTH+1];
  end

  // Control FSM, iteration counter and sign fix-up next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_flag_d = dz_flag_q;
    sr_ld     = 1'b0;
    sr_shift  = 1'b0;
    sr_din    = '0;
    sr_lsb    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_neg_d = signed_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rem_neg_d = signed_en & dividend[WIDTH-1];
          dvs_d     = dvs_mag;
          dz_d      = (divisor == '0);
          cnt_d     = '0;
          sr_ld     = 1'b1;
          sr_din    = {{(WIDTH+1){1'b0}}, dvd_mag};
          state_d   = (divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (fits) begin
          sr_ld  = 1'b1;
          sr_din = {diff[WIDTH:0], rq_shl[WIDTH-1:1], 1'b1};
        end else begin
          sr_shift = 1'b1;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dz_q) begin
          // Q still holds |dividend|, so re-signing it restores the dividend.
          quot_d = '1;
          rem_d  = rem_neg_q ? -q_cur : q_cur;
        end else begin
          quot_d = quo_neg_q ? -q_cur : q_cur;
          rem_d  = rem_neg_q ? -r_mag : r_mag;
        end
        dz_flag_d = dz_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_flag_q <= dz_flag_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_flag_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed testbench for booth_seq_divider with hand-computed expectations.
module tb_booth_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         clr_n;
  logic         start;
  logic         signed_en;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  booth_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .signed_en   (signed_en),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation from IDLE and collects latency (edges after the
  // start edge until done), busy cycles and results. lat = -1 on timeout.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    @(negedge clk);
    signed_en = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'hdead; divisor = 16'hbeef; signed_en = ~s;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) lat = -1;
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; signed_en = 1'b0; dividend = '0; divisor = '0;
    #23;
    n_vec++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    n_vec++;
    if (quotient !== '0 || remainder !== '0) begin
      n_err++; $display("FAIL reset_data: got q=%h r=%h expected 0/0", quotient, remainder);
    end
    @(negedge clk); clr_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] a [4] = '{16'd100, 16'hffff, 16'd5, 16'h8000};
    logic [W-1:0] b [4] = '{16'd7, 16'd1, 16'd9, 16'hffff};
    logic [W-1:0] eq [4] = '{16'd14, 16'hffff, 16'd0, 16'd0};
    logic [W-1:0] er [4] = '{16'd2, 16'd0, 16'd5, 16'h8000};
    int lat, bcnt; logic [W-1:0] q, r; logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, a[i], b[i], lat, bcnt, q, r, dz);
      n_vec++;
      if (lat !== W + 1) begin
        n_err++; $display("FAIL unsigned_latency[%0d]: got %0d expected %0d", i, lat, W + 1);
      end
      n_vec++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        n_err++; $display("FAIL unsigned_result[%0d]: got q=%h r=%h dz=%b expected q=%h r=%h dz=0",
                          i, q, r, dz, eq[i], er[i]);
      end
      if (i == 0) begin
        n_vec++;
        if (bcnt !== W + 1) begin
          n_err++; $display("FAIL unsigned_busy_cycles: got %0d expected %0d", bcnt, W + 1);
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd14) begin
          n_err++; $display("FAIL done_pulse_hold: got done=%b busy=%b q=%h expected 0 0 000e",
                            done, busy, quotient);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] a [3] = '{16'hff9c, 16'd100, 16'h8000};
    logic [W-1:0] b [3] = '{16'd7, 16'hfff9, 16'hffff};
    logic [W-1:0] eq [3] = '{16'hfff2, 16'hfff2, 16'h8000};
    logic [W-1:0] er [3] = '{16'hfffe, 16'd2, 16'd0};
    int lat, bcnt; logic [W-1:0] q, r; logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, a[i], b[i], lat, bcnt, q, r, dz);
      n_vec++;
      if (lat !== W + 1) begin
        n_err++; $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, W + 1);
      end
      n_vec++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        n_err++; $display("FAIL signed_result[%0d]: got q=%h r=%h dz=%b expected q=%h r=%h dz=0",
                          i, q, r, dz, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic         s  [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] a  [3] = '{16'd1234, 16'd1234, 16'hfffb};
    int lat, bcnt; logic [W-1:0] q, r; logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(s[i], a[i], 16'd0, lat, bcnt, q, r, dz);
      n_vec++;
      if (lat !== 1 || bcnt !== 1) begin
        n_err++; $display("FAIL dz_timing[%0d]: got lat=%0d busy=%0d expected 1/1", i, lat, bcnt);
      end
      n_vec++;
      if (q !== 16'hffff || r !== a[i] || dz !== 1'b1) begin
        n_err++; $display("FAIL dz_result[%0d]: got q=%h r=%h dz=%b expected q=ffff r=%h dz=1",
                          i, q, r, dz, a[i]);
      end
    end
    // Flag must clear on the next normal result.
    run_op(1'b0, 16'd9, 16'd3, lat, bcnt, q, r, dz);
    n_vec++;
    if (q !== 16'd3 || r !== 16'd0 || dz !== 1'b0) begin
      n_err++; $display("FAIL dz_clear: got q=%h r=%h dz=%b expected 3 0 0", q, r, dz);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    signed_en = 1'b0; dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      start = (k == 2 || k == 17 || k == 18);
      if (k == 2) begin dividend = 16'd1000; divisor = 16'd3; end
      else if (k >= 17) begin dividend = 16'd300; divisor = 16'd11; end
      @(posedge clk); #1;
      if (k == 2) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++; $display("FAIL ignore_busy_start: got busy=%b done=%b expected 1 0", busy, done);
        end
      end
      if (k == 17) begin
        n_vec++;
        if (done !== 1'b1 || quotient !== 16'd14 || remainder !== 16'd2) begin
          n_err++; $display("FAIL ignore_result: got done=%b q=%h r=%h expected 1 000e 0002",
                            done, quotient, remainder);
        end
      end
      if (k == 18) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++; $display("FAIL accept_after_done: got busy=%b done=%b expected 1 0", busy, done);
        end
      end
    end
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== W + 1 || quotient !== 16'd27 || remainder !== 16'd3) begin
      n_err++; $display("FAIL second_op: got lat=%0d q=%h r=%h expected %0d 001b 0003",
                        lat, quotient, remainder, W + 1);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt; logic [W-1:0] q, r; logic dz;
    logic done_seen;
    @(negedge clk);
    signed_en = 1'b0; dividend = 16'd200; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #1 clr_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      n_err++; $display("FAIL async_reset: got busy=%b done=%b dz=%b q=%h r=%h expected all 0",
                        busy, done, div_by_zero, quotient, remainder);
    end
    done_seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; done_seen |= done; end
    @(negedge clk); clr_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; done_seen |= done; end
    n_vec++;
    if (done_seen !== 1'b0) begin
      n_err++; $display("FAIL aborted_done: got done_seen=%b expected 0", done_seen);
    end
    run_op(1'b0, 16'd200, 16'd3, lat, bcnt, q, r, dz);
    n_vec++;
    if (lat !== W + 1 || q !== 16'd66 || r !== 16'd2 || dz !== 1'b0) begin
      n_err++; $display("FAIL after_reset_op: got lat=%0d q=%h r=%h dz=%b expected %0d 0042 0002 0",
                        lat, q, r, dz, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
